// File: rtl/rx_libnet_mc_pkg.sv
// Shared libnet definitions: receive state encoding, default header field offsets,
// and the channel-id width helper used by the rx and tx libnet blocks.
package rx_libnet_mc_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        STRM = 2'd1,
        DROP = 2'd2
    } libnet_state_t;

    localparam int LIBNET_SEQ_LSB = 344;
    localparam int LIBNET_ACK_BIT = 376;
    localparam int LIBNET_SYN_BIT = 377;
    localparam int LIBNET_CH_LSB  = 378;
    localparam int LIBNET_CH_FW   = 4;

    localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/rx_libnet_mc_axis_pipe.sv
// One-deep registered AXI-Stream stage; the upstream only loads when the slot is
// empty or draining this cycle, so a held beat never changes under back-pressure.
module rx_libnet_mc_axis_pipe #(
    parameter int DATA_W = 512,
    parameter int USER_W = 64,
    parameter int DEST_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_W-1:0]     i_tdata,
    input  logic [DATA_W/8-1:0]   i_tkeep,
    input  logic [USER_W-1:0]     i_tuser,
    input  logic [DEST_W-1:0]     i_tdest,
    input  logic                  i_tlast,
    input  logic                  i_tready,
    output logic                  o_tvalid,
    output logic [DATA_W-1:0]     o_tdata,
    output logic [DATA_W/8-1:0]   o_tkeep,
    output logic [USER_W-1:0]     o_tuser,
    output logic [DEST_W-1:0]     o_tdest,
    output logic                  o_tlast
);

    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_keep;
    logic [USER_W-1:0]   r_user;
    logic [DEST_W-1:0]   r_dest;
    logic                r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_user  <= '0;
            r_dest  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_tdata;
            r_keep  <= i_tkeep;
            r_user  <= i_tuser;
            r_dest  <= i_tdest;
            r_last  <= i_tlast;
        end else if (r_valid && i_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_tvalid = r_valid;
    assign o_tdata  = r_data;
    assign o_tkeep  = r_keep;
    assign o_tuser  = r_user;
    assign o_tdest  = r_dest;
    assign o_tlast  = r_last;

endmodule

// File: rtl/rx_libnet_mc.sv
// Multi-channel receive libnet: parses the header beat, tracks a per-channel expected
// sequence number, streams in-order payload with tdest=channel and acks every accepted header.
module rx_libnet_mc
    import rx_libnet_mc_pkg::*;
#(
    parameter int DATA_W  = 512,
    parameter int USER_W  = 64,
    parameter int NUM_CH  = 4,
    parameter int SEQ_W   = 32,
    parameter int SEQ_LSB = LIBNET_SEQ_LSB,
    parameter int ACK_BIT = LIBNET_ACK_BIT,
    parameter int SYN_BIT = LIBNET_SYN_BIT,
    parameter int CH_LSB  = LIBNET_CH_LSB,
    localparam int CH_W   = chWidth(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     rx_tdata,
    input  logic [DATA_W/8-1:0]   rx_tkeep,
    input  logic [USER_W-1:0]     rx_tuser,
    input  logic                  rx_tlast,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    output logic [DATA_W-1:0]     tx_tdata,
    output logic [DATA_W/8-1:0]   tx_tkeep,
    output logic [USER_W-1:0]     tx_tuser,
    output logic [CH_W-1:0]       tx_tdest,
    output logic                  tx_tlast,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic [SEQ_W-1:0]      ack_seq,
    output logic [CH_W-1:0]       ack_chan,
    output logic                  ack_valid,
    input  logic                  ack_ready,
    output logic [31:0]           drop_cnt
);

    // A layout whose fields overrun the beat or alias the flags never yields a valid channel.
    localparam bit LAYOUT_OK = (SEQ_LSB + SEQ_W <= DATA_W) && (CH_LSB + LIBNET_CH_FW <= DATA_W)
                            && (SYN_BIT < DATA_W) && (ACK_BIT < DATA_W) && (ACK_BIT != SYN_BIT);

    libnet_state_t       r_state;
    logic [SEQ_W-1:0]    r_seqExp [NUM_CH];
    logic                r_ackValid;
    logic [SEQ_W-1:0]    r_ackSeq;
    logic [CH_W-1:0]     r_ackChan;
    logic [CH_W-1:0]     r_curCh;
    logic [31:0]         r_dropCnt;

    logic                    w_rxReady;
    logic                    w_rxFire;
    logic                    w_hdrFire;
    logic [LIBNET_CH_FW-1:0] w_hdrCh;
    logic [CH_W-1:0]         w_chIdx;
    logic [SEQ_W-1:0]        w_hdrSeq;
    logic [SEQ_W-1:0]        w_expSeq;
    logic                    w_hdrSyn;
    logic                    w_chOk;
    logic                    w_seqMatch;
    logic                    w_hdrDrop;
    logic                    w_hdrAck;
    logic [SEQ_W-1:0]        w_ackSeqNext;
    logic                    w_txValid;

    always_comb begin
        w_rxReady = 1'b1;
        unique case (r_state)
            HDR:     w_rxReady = !(r_ackValid && !ack_ready);
            STRM:    w_rxReady = !w_txValid || tx_tready;
            DROP:    w_rxReady = 1'b1;
            default: w_rxReady = 1'b1;
        endcase
    end

    assign w_rxFire   = rx_tvalid && w_rxReady;
    assign w_hdrFire  = w_rxFire && (r_state == HDR);
    assign w_hdrCh    = rx_tdata[CH_LSB +: LIBNET_CH_FW];
    assign w_chIdx    = w_hdrCh[CH_W-1:0];
    assign w_hdrSeq   = rx_tdata[SEQ_LSB +: SEQ_W];
    assign w_hdrSyn   = rx_tdata[SYN_BIT];
    assign w_chOk     = LAYOUT_OK && ({1'b0, w_hdrCh} < 5'(NUM_CH));
    assign w_expSeq   = r_seqExp[w_chIdx];
    assign w_seqMatch = (w_hdrSeq == w_expSeq);

    always_comb begin
        w_hdrDrop    = 1'b0;
        w_hdrAck     = 1'b0;
        w_ackSeqNext = w_expSeq;
        if (!w_chOk) begin
            w_hdrDrop = 1'b1;
        end else if (w_hdrSyn) begin
            w_hdrAck     = 1'b1;
            w_ackSeqNext = w_hdrSeq;
        end else if (w_seqMatch) begin
            w_hdrAck     = 1'b1;
            w_ackSeqNext = w_hdrSeq + 1'b1;
        end else begin
            w_hdrDrop = 1'b1;
            w_hdrAck  = 1'b1;
        end
    end

    // A new ack set in the same cycle the old one drains wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HDR;
            r_ackValid <= 1'b0;
            r_ackSeq   <= '0;
            r_ackChan  <= '0;
            r_curCh    <= '0;
            r_dropCnt  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_seqExp[c] <= '0;
            end
        end else begin
            if (r_ackValid && ack_ready) begin
                r_ackValid <= 1'b0;
            end
            if (w_hdrFire) begin
                if (w_hdrDrop && (r_dropCnt != DROP_CNT_MAX)) begin
                    r_dropCnt <= r_dropCnt + 32'd1;
                end
                if (w_hdrAck) begin
                    r_ackValid <= 1'b1;
                    r_ackChan  <= w_chIdx;
                    r_ackSeq   <= w_ackSeqNext;
                end
                if (w_chOk && (w_hdrSyn || w_seqMatch)) begin
                    r_seqExp[w_chIdx] <= w_ackSeqNext;
                end
                if (!rx_tlast) begin
                    if (w_chOk && !w_hdrSyn && w_seqMatch) begin
                        r_state <= STRM;
                        r_curCh <= w_chIdx;
                    end else begin
                        r_state <= DROP;
                    end
                end
            end else if (w_rxFire && rx_tlast) begin
                r_state <= HDR;
            end
        end
    end

    rx_libnet_mc_axis_pipe #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .DEST_W (CH_W)
    ) u_txPipe (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_rxFire && (r_state == STRM)),
        .i_tdata  (rx_tdata),
        .i_tkeep  (rx_tkeep),
        .i_tuser  (rx_tuser),
        .i_tdest  (r_curCh),
        .i_tlast  (rx_tlast),
        .i_tready (tx_tready),
        .o_tvalid (w_txValid),
        .o_tdata  (tx_tdata),
        .o_tkeep  (tx_tkeep),
        .o_tuser  (tx_tuser),
        .o_tdest  (tx_tdest),
        .o_tlast  (tx_tlast)
    );

    assign rx_tready = w_rxReady;
    assign tx_tvalid = w_txValid;
    assign ack_valid = r_ackValid;
    assign ack_seq   = r_ackSeq;
    assign ack_chan  = r_ackChan;
    assign drop_cnt  = r_dropCnt;

endmodule
